alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler.sv | 112 +++++++++++
 tb/tb_alu_op_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin scheduler that time-shares one external adder.
// Optional build macro ALU_SUB_EN enables per-request subtraction (two's-complement of right).
module alu_op_scheduler #(
  parameter int ADD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [9:0] req0_operands,
  input  logic       req0_sub,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [9:0] req1_operands,
  input  logic       req1_sub,
  output logic       req1_ready,
  output logic [4:0] add_left,
  output logic [4:0] add_right,
  input  logic [4:0] add_result,
  input  logic       add_sign,
  output logic       res_valid,
  output logic [4:0] res_value,
  output logic       res_sign,
  output logic       res_owner,
  input  logic       res_ready,
  output logic       busy
);

  // A latency of zero still needs one settle cycle for the adder.
  localparam logic [3:0] LAT = (ADD_LATENCY <= 0) ? 4'd1 : 4'(ADD_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       take;
  logic [4:0] left_in;
  logic [4:0] right_in;
  logic [4:0] right_eff;

  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign take   = (state == IDLE) && (grant0 || grant1);

  // Ready is forced low while reset is asserted even though the state reads IDLE.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign busy       = (state != IDLE);

  assign left_in  = grant1 ? req1_operands[9:5] : req0_operands[9:5];
  assign right_in = grant1 ? req1_operands[4:0] : req0_operands[4:0];

`ifdef ALU_SUB_EN
  logic sub_in;
  assign sub_in    = grant1 ? req1_sub : req0_sub;
  assign right_eff = sub_in ? (~right_in + 5'd1) : right_in;
`else
  logic unused_sub;
  assign unused_sub = req0_sub | req1_sub;
  assign right_eff  = right_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      add_left   <= 5'd0;
      add_right  <= 5'd0;
      res_valid  <= 1'b0;
      res_value  <= 5'd0;
      res_sign   <= 1'b0;
      res_owner  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            add_left   <= left_in;
            add_right  <= right_eff;
            res_owner  <= grant1;
            last_grant <= grant1;
            cnt        <= LAT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd1) begin
            res_value <= add_result;
            res_sign  <= add_sign;
            cnt       <= 4'd0;
            state     <= RESULT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESULT: begin
          // First RESULT cycle only raises valid; the captured value is already stable.
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench: directed ops on a latency-1 instance, latency/reset checks on a latency-3 instance.
module tb_alu_op_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       req0_valid, req0_sub, req0_ready;
  logic       req1_valid, req1_sub, req1_ready;
  logic [9:0] req0_operands, req1_operands;
  logic [4:0] add_left, add_right, add_result, res_value;
  logic       add_sign, res_valid, res_sign, res_owner, res_ready, busy;

  logic       v3, s3, rdy3, u_valid, u_sub, u_ready;
  logic [9:0] ops3, u_ops;
  logic [4:0] al3, ar3, ares3, rv3;
  logic       asg3, res_valid3, rs3, ro3, res_ready3, busy3;

  typedef struct {
    logic       owner;
    logic [4:0] val;
    logic       sign;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: 6-bit sum, bit 5 reported as the sign flag.
  assign {add_sign, add_result} = {1'b0, add_left} + {1'b0, add_right};
  assign {asg3, ares3}          = {1'b0, al3} + {1'b0, ar3};

  alu_op_scheduler #(.ADD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_operands(req0_operands), .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_operands(req1_operands), .req1_sub(req1_sub), .req1_ready(req1_ready),
    .add_left(add_left), .add_right(add_right), .add_result(add_result), .add_sign(add_sign),
    .res_valid(res_valid), .res_value(res_value), .res_sign(res_sign), .res_owner(res_owner),
    .res_ready(res_ready), .busy(busy)
  );

  alu_op_scheduler #(.ADD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v3), .req0_operands(ops3), .req0_sub(s3), .req0_ready(rdy3),
    .req1_valid(u_valid), .req1_operands(u_ops), .req1_sub(u_sub), .req1_ready(u_ready),
    .add_left(al3), .add_right(ar3), .add_result(ares3), .add_sign(asg3),
    .res_valid(res_valid3), .res_value(rv3), .res_sign(rs3), .res_owner(ro3),
    .res_ready(res_ready3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Raise valid, wait for the grant, return the transfer edge index.
  task automatic send(input bit who, input logic [4:0] l, input logic [4:0] r,
                      input logic s, output int t);
    if (who) begin
      req1_operands = {l, r}; req1_sub = s; req1_valid = 1'b1;
    end else begin
      req0_operands = {l, r}; req0_sub = s; req0_valid = 1'b1;
    end
    t = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) begin
        t = cyc + 1;
        break;
      end
    end
    chk("grant_seen", (t >= 0), 1);
    align();
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_res(input int t, input int lat, input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    chk(name, cyc, t + lat + 1);
  endtask

  // Monitor: every accepted result is popped and compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", res_value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("res owner=%0d value=%0h sign=%0d (exp %0d %0h %0d)",
                 res_owner, res_value, res_sign, e.owner, e.val, e.sign);
        if (res_owner !== e.owner || res_value !== e.val || res_sign !== e.sign) begin
          errors++;
          $display("FAIL result actual=%0d/%0h/%0d required=%0d/%0h/%0d",
                   res_owner, res_value, res_sign, e.owner, e.val, e.sign);
        end
      end
    end
  end

  initial begin
    int t, t0, t1;
    bit seen;
    exp_t e;
    logic [4:0] exp_ar;
    rst_n = 1'b0; res_ready = 1'b1; res_ready3 = 1'b1;
    req0_valid = 0; req0_sub = 0; req0_operands = '0;
    req1_valid = 0; req1_sub = 0; req1_operands = '0;
    v3 = 0; s3 = 0; ops3 = '0; u_valid = 0; u_sub = 0; u_ops = '0;
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1; req1_valid = 1'b1;

    // Reset state, with requests pending
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_add", {add_left, add_right}, 0);
    chk("rst_owner", res_owner, 0);
    align();
    req0_valid = 0; req1_valid = 0; rst_n = 1'b1;

    // Tie after reset: req0 first, req1 after a one-cycle bubble
    e = '{1'b0, 5'd3, 1'b0};  sb.push_back(e);
    e = '{1'b1, 5'd15, 1'b0}; sb.push_back(e);
    req0_operands = {5'd1, 5'd2};  req0_valid = 1'b1;
    req1_operands = {5'd10, 5'd5}; req1_valid = 1'b1;
    @(negedge clk);
    chk("tie_ready0", req0_ready, 1);
    chk("tie_ready1", req1_ready, 0);
    t0 = cyc + 1;
    align();
    req0_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req1_ready) break;
    end
    chk("tie_second_grant_cycle", cyc, t0 + 3);
    t1 = cyc + 1;
    align();
    req1_valid = 1'b0;
    wait_res(t1, 1, "tie_req1_latency");
    align();

    // Single add 3+4
    e = '{1'b0, 5'd7, 1'b0}; sb.push_back(e);
    send(0, 5'd3, 5'd4, 1'b0, t);
    wait_res(t, 1, "add_latency");
    @(posedge clk);
    @(negedge clk);
    chk("add_back_idle", busy, 0);
    align();

    // Back-pressure: 20+20 = 40 -> value 8, sign 1; req1 waits meanwhile
    res_ready = 1'b0;
    e = '{1'b0, 5'd8, 1'b1}; sb.push_back(e);
    e = '{1'b1, 5'd5, 1'b0}; sb.push_back(e);
    send(0, 5'd20, 5'd20, 1'b0, t);
    wait_res(t, 1, "bp_latency");
    req1_operands = {5'd2, 5'd3}; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {res_valid, res_value, res_sign, req0_ready, req1_ready}, {1'b1, 5'd8, 1'b1, 2'b00});
    end
    align();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle", {busy, req1_ready}, 2'b01);
    t = cyc + 1;
    align();
    req1_valid = 1'b0;
    wait_res(t, 1, "bp_req1_latency");
    align();

    // Subtraction 9-2 (macro-dependent)
`ifdef ALU_SUB_EN
    exp_ar = 5'b11110; e = '{1'b0, 5'd7, 1'b1};
`else
    exp_ar = 5'b00010; e = '{1'b0, 5'd11, 1'b0};
`endif
    sb.push_back(e);
    send(0, 5'd9, 5'd2, 1'b1, t);
    @(negedge clk);
    chk("sub_add_left", add_left, 5'd9);
    chk("sub_add_right", add_right, exp_ar);
    wait_res(t, 1, "sub_latency");
    align();

    // A pulse of req0_valid while busy must not produce a grant later
    e = '{1'b1, 5'd2, 1'b0}; sb.push_back(e);
    send(1, 5'd1, 5'd1, 1'b0, t);
    req0_operands = {5'd4, 5'd4}; req0_valid = 1'b1;
    align();
    req0_valid = 1'b0;
    wait_res(t, 1, "drop_latency");
    repeat (3) @(negedge clk);
    chk("drop_no_grant", {busy, req0_ready}, 2'b00);
    align();

    // Latency-3 instance: operands stable for 3 cycles, res_valid at T+4
    ops3 = {5'd6, 5'd5}; v3 = 1'b1;
    @(negedge clk);
    chk("lat3_ready", rdy3, 1);
    t = cyc + 1;
    align();
    v3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) chk("lat3_operands", {al3, ar3}, {5'd6, 5'd5});
      chk("lat3_res_valid", res_valid3, (k == 4));
    end
    chk("lat3_value", {rv3, rs3, ro3}, {5'd11, 1'b0, 1'b0});
    repeat (2) align();

    // Reset mid-EXEC on the latency-3 instance
    ops3 = {5'd1, 5'd1}; v3 = 1'b1;
    align();
    v3 = 1'b0;
    @(negedge clk);
    chk("midexec_busy", busy3, 1);
    rst_n = 1'b0;
    #1;
    chk("midexec_rst_outs", {busy3, al3, ar3, res_valid3, rv3, rs3, ro3, rdy3, u_ready}, 0);
    align();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid3) seen = 1'b1;
    end
    chk("midexec_no_result", seen, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
